// File: rtl/weave_sum_acc.sv
// N-channel unsigned adder with wrap/saturate and one-shot/accumulate modes.
// Sticky overflow, beat counter, one-entry valid/ready output register.
module weave_sum_acc #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned N_CH  = 2,
   parameter int unsigned CNT_W = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_CH*WIDTH-1:0]   in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [1:0]              mode,
   input  logic                    clear,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    ovf,
   output logic [CNT_W-1:0]        beat_cnt
);

   localparam int unsigned SumW = WIDTH + $clog2(N_CH);
   // One extra bit so accumulator + full sum cannot truncate.
   localparam int unsigned TotW = SumW + 1;
   localparam logic [TotW-1:0] MaxVal = {{(TotW - WIDTH){1'b0}}, {WIDTH{1'b1}}};

   logic [WIDTH-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;

   logic             acc_en;
   logic             acc_mode;
   logic             sat_mode;
   logic [SumW-1:0]  sum;
   logic [WIDTH-1:0] acc_base;
   logic [TotW-1:0]  pre_red;
   logic             beat_ovf;
   logic [WIDTH-1:0] result;

   assign in_ready = !out_valid_q || out_ready;
   assign acc_en   = in_valid && in_ready;
   assign acc_mode = mode[1];
   assign sat_mode = mode[0];

   always_comb begin
      sum = '0;
      for (int i = 0; i < int'(N_CH); i++) begin
         sum = sum + SumW'(in_data[i*WIDTH +: WIDTH]);
      end
   end

   always_comb begin
      acc_base = clear ? '0 : acc_q;
      if (acc_mode) begin
         pre_red = TotW'(sum) + TotW'(acc_base);
      end else begin
         pre_red = TotW'(sum);
      end
      beat_ovf = pre_red > MaxVal;
      if (sat_mode && beat_ovf) begin
         result = '1;
      end else begin
         result = pre_red[WIDTH-1:0];
      end
   end

   always_comb begin
      acc_d       = acc_q;
      ovf_d       = ovf_q;
      cnt_d       = cnt_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;

      if (acc_en) begin
         if (acc_mode) begin
            acc_d = result;
         end else if (clear) begin
            acc_d = '0;
         end
         // Clear on an accepting cycle keeps only this beat's overflow.
         ovf_d       = (ovf_q && !clear) || beat_ovf;
         cnt_d       = clear ? CNT_W'(1) : cnt_q + CNT_W'(1);
         out_data_d  = result;
         out_valid_d = 1'b1;
      end else begin
         if (clear) begin
            acc_d = '0;
            ovf_d = 1'b0;
            cnt_d = '0;
         end
         if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         cnt_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         ovf_q       <= ovf_d;
         cnt_q       <= cnt_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign ovf       = ovf_q;
   assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_weave_sum_acc.sv
// Randomised + directed bench for weave_sum_acc against an arithmetic reference model.
module tb_weave_sum_acc;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  mode;
   logic        clear;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        ovf;
   logic [7:0]  beat_cnt;

   // Narrow 4-channel build for the 4-bit saturation case.
   logic [15:0] s_in_data;
   logic        s_in_valid;
   logic        s_in_ready;
   logic [1:0]  s_mode;
   logic        s_clear;
   logic [3:0]  s_out_data;
   logic        s_out_valid;
   logic        s_out_ready;
   logic        s_ovf;
   logic [7:0]  s_beat_cnt;

   weave_sum_acc #(.WIDTH(8), .N_CH(2), .CNT_W(8)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .clear     (clear),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ovf       (ovf),
      .beat_cnt  (beat_cnt)
   );

   weave_sum_acc #(.WIDTH(4), .N_CH(4), .CNT_W(8)) u_dut_small (
      .clk       (clk),
      .rst       (rst),
      .in_data   (s_in_data),
      .in_valid  (s_in_valid),
      .in_ready  (s_in_ready),
      .mode      (s_mode),
      .clear     (s_clear),
      .out_data  (s_out_data),
      .out_valid (s_out_valid),
      .out_ready (s_out_ready),
      .ovf       (s_ovf),
      .beat_cnt  (s_beat_cnt)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model state.
   int m_acc, m_cnt, m_out;
   bit m_ovf, m_ov;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_acc = 0; m_cnt = 0; m_out = 0; m_ovf = 0; m_ov = 0;
   endtask

   task automatic model_step(input bit take, input int a, input int b, input int md,
                             input bit clr, input bit ordy);
      int s, t, r;
      bit bo;
      if (take) begin
         s  = a + b;
         t  = (md >= 2) ? s + (clr ? 0 : m_acc) : s;
         bo = t > 255;
         r  = (md % 2 == 1) ? (bo ? 255 : t) : t % 256;
         if (md >= 2) m_acc = r;
         else if (clr) m_acc = 0;
         m_ovf = (clr ? 1'b0 : m_ovf) | bo;
         m_cnt = clr ? 1 : (m_cnt + 1) % 256;
         m_out = r;
         m_ov  = 1;
      end else begin
         if (clr) begin
            m_acc = 0; m_ovf = 0; m_cnt = 0;
         end
         if (m_ov && ordy) m_ov = 0;
      end
   endtask

   task automatic check_outs(input string tag);
      check_eq({tag, "_data"}, out_data, m_out);
      check_eq({tag, "_valid"}, out_valid, m_ov);
      check_eq({tag, "_ovf"}, ovf, m_ovf);
      check_eq({tag, "_cnt"}, beat_cnt, m_cnt);
   endtask

   // Called at posedge+1: drive, check in_ready, clock, update model, check outputs.
   task automatic cyc(input bit v, input int a, input int b, input int md,
                      input bit clr, input bit ordy);
      bit rdy;
      in_valid  = v;
      in_data   = {b[7:0], a[7:0]};
      mode      = md[1:0];
      clear     = clr;
      out_ready = ordy;
      #1;
      rdy = !m_ov || ordy;
      check_eq("in_ready", in_ready, rdy);
      @(posedge clk);
      #1;
      model_step(v && rdy, a, b, md, clr, ordy);
      check_outs("cyc");
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 0; clear = 0; out_ready = 0; in_data = '0; mode = 2'd0;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      s_in_data = '0; s_in_valid = 0; s_mode = 2'd0; s_clear = 0; s_out_ready = 1;
      do_reset();
      check_outs("reset");
      check_eq("reset_in_ready", in_ready, 1);

      // Wrap sum
      cyc(1, 200, 100, 0, 0, 1);
      check_eq("t1_sum", out_data, 44);
      check_eq("t1_ovf", ovf, 1);
      check_eq("t1_cnt", beat_cnt, 1);
      cyc(1, 3, 4, 0, 0, 1);
      check_eq("t1_sum2", out_data, 7);
      check_eq("t1_ovf2", ovf, 1);

      // Saturating sum, then clear alone
      do_reset();
      cyc(1, 200, 100, 1, 0, 0);
      check_eq("t2_sat", out_data, 255);
      check_eq("t2_ovf", ovf, 1);
      cyc(0, 0, 0, 1, 1, 0);
      check_eq("t2_clr_ovf", ovf, 0);
      check_eq("t2_clr_cnt", beat_cnt, 0);
      check_eq("t2_clr_data", out_data, 255);
      check_eq("t2_clr_valid", out_valid, 1);

      // Accumulate wrap, then accumulate saturate
      do_reset();
      cyc(1, 10, 5, 2, 0, 1);
      check_eq("t3_a1", out_data, 15);
      cyc(1, 20, 0, 2, 0, 1);
      check_eq("t3_a2", out_data, 35);
      check_eq("t3_ovf2", ovf, 0);
      cyc(1, 250, 0, 2, 0, 1);
      check_eq("t3_a3", out_data, 29);
      check_eq("t3_ovf3", ovf, 1);
      do_reset();
      cyc(1, 250, 0, 3, 0, 1);
      check_eq("t3_s1", out_data, 250);
      cyc(1, 6, 4, 3, 0, 1);
      check_eq("t3_s2", out_data, 255);
      check_eq("t3_sovf", ovf, 1);

      // Backpressure
      do_reset();
      cyc(1, 1, 2, 0, 0, 0);
      cyc(1, 3, 4, 0, 0, 0);
      check_eq("t4_stall_data", out_data, 3);
      check_eq("t4_stall_rdy", in_ready, 0);
      cyc(1, 3, 4, 0, 0, 0);
      check_eq("t4_one_acc", beat_cnt, 1);
      cyc(1, 3, 4, 0, 0, 1);
      check_eq("t4_flow1", out_data, 7);
      cyc(1, 5, 6, 0, 0, 1);
      check_eq("t4_flow2", out_data, 11);
      check_eq("t4_cnt", beat_cnt, 3);

      // Clear with accept; accumulator retained across mode 0 beats
      do_reset();
      cyc(1, 200, 100, 0, 0, 1);
      cyc(1, 100, 0, 2, 0, 1);
      check_eq("t5_acc", out_data, 100);
      cyc(1, 7, 8, 2, 1, 1);
      check_eq("t5_data", out_data, 15);
      check_eq("t5_cnt", beat_cnt, 1);
      check_eq("t5_ovf", ovf, 0);

      // Asynchronous reset while stalled
      cyc(1, 200, 100, 1, 0, 0);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_eq("t6_rst_data", out_data, 0);
      check_eq("t6_rst_valid", out_valid, 0);
      check_eq("t6_rst_ovf", ovf, 0);
      check_eq("t6_rst_cnt", beat_cnt, 0);
      check_eq("t6_rst_rdy", in_ready, 1);
      do_reset();

      // Beat counter wrap
      for (int i = 0; i < 256; i++) begin
         cyc(1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 0, 0, 1);
      end
      check_eq("t6_wrap", beat_cnt, 0);

      // 4x4-bit build
      do_reset();
      check_eq("s_rst_valid", s_out_valid, 0);
      s_in_data = 16'hFFFF; s_mode = 2'd1; s_in_valid = 1;
      @(posedge clk); #1;
      check_eq("s_sat", s_out_data, 15);
      check_eq("s_ovf", s_ovf, 1);
      check_eq("s_cnt", s_beat_cnt, 1);
      s_in_data = 16'h1234; s_mode = 2'd0;
      @(posedge clk); #1;
      check_eq("s_sum", s_out_data, 10);
      check_eq("s_ovf_sticky", s_ovf, 1);
      s_in_valid = 0;

      // Randomised traffic
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 3) != 0),
             int'($urandom_range(0, 255)),
             int'($urandom_range(0, 255)),
             int'($urandom_range(0, 3)),
             ($urandom_range(0, 19) == 0),
             ($urandom_range(0, 9) < 7));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
